// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial, LSB-first subtractor computing a - b - bin
// over WIDTH cycles with one registered full-subtractor step per cycle.
// A start/busy/done handshake frames each operation. diff, bout and ovf
// hold their values until the next accepted start.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    // Full-subtractor difference bit.
    function automatic logic fs_diff(input logic x, input logic y, input logic bi);
        return x ^ y ^ bi;
    endfunction

    // Full-subtractor borrow: borrow when x < y, or when x == y and a borrow arrives.
    function automatic logic fs_borrow(input logic x, input logic y, input logic bi);
        return (~x & y) | (~(x ^ y) & bi);
    endfunction

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic             br_q, br_d;
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic             dbit;
    logic             borrow_nxt;
    logic             last_bit;

    assign dbit       = fs_diff(sa_q[0], sb_q[0], br_q);
    assign borrow_nxt = fs_borrow(sa_q[0], sb_q[0], br_q);
    assign last_bit   = (cnt_q == CNT_W'(WIDTH - 1));

    // Next-state logic: capture on an accepted start, one bit per SHIFT cycle.
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        br_d    = br_q;
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SHIFT;
                    sa_d    = a;
                    sb_d    = b;
                    br_d    = bin;
                    amsb_d  = a[WIDTH-1];
                    bmsb_d  = b[WIDTH-1];
                    cnt_d   = '0;
                end
            end
            S_SHIFT: begin
                diff_d = {dbit, diff_q[WIDTH-1:1]};
                sa_d   = sa_q >> 1;
                sb_d   = sb_q >> 1;
                br_d   = borrow_nxt;
                cnt_d  = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    // Last bit: the difference MSB is dbit, so the signed
                    // overflow test can be made on this same edge.
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    bout_d  = borrow_nxt;
                    ovf_d   = (amsb_q ^ bmsb_q) & (amsb_q ^ dbit);
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; an asynchronous reset abandons any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            br_q    <= 1'b0;
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            br_q    <= br_d;
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == S_SHIFT);
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule
